// File: rtl/clk_gate_ctrl.sv
// clk_gate_ctrl: N-channel glitch-free clock gating with software enable and idle auto-gating
module clk_gate_ctrl #(
  parameter int N_CH        = 4,
  parameter int IDLE_CYCLES = 16,
  parameter int MIN_ON      = 4
) (
  input  logic            in_clk,
  input  logic            rst,
  input  logic [N_CH-1:0] sw_en,
  input  logic [N_CH-1:0] auto_en,
  input  logic [N_CH-1:0] busy,
  output logic [N_CH-1:0] out_clk,
  output logic [N_CH-1:0] clk_active,
  output logic [N_CH-1:0] wake_pulse
);
  localparam int MAX_CNT = IDLE_CYCLES > MIN_ON ? IDLE_CYCLES : MIN_ON;
  localparam int CNT_W = $clog2(MAX_CNT + 1);
  localparam logic [CNT_W-1:0] IDLE_LAST = CNT_W'(IDLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] MIN_LAST = CNT_W'(MIN_ON - 1);
  typedef enum logic [1:0] {OFF, RUN, GATED} state_t;
  logic [N_CH-1:0] en_n_q, en_n_d;
  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    state_t state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
    logic mon_q, mon_d, act_q, wake_q, wake_d;
    assign cnt_inc = cnt_q == '1 ? cnt_q : cnt_q + 1'b1;
    // next state: mon_q marks the min-on window, during which cnt times the window instead of idleness
    always_comb begin
      state_d = state_q;
      cnt_d = cnt_q;
      mon_d = mon_q;
      wake_d = 1'b0;
      case (state_q)
        OFF: if (sw_en[i]) begin
          state_d = RUN;
          cnt_d = '0;
          mon_d = 1'b1;
        end
        RUN: if (!sw_en[i]) state_d = OFF;
        else if (mon_q) begin
          cnt_d = cnt_q == MIN_LAST ? '0 : cnt_inc;
          mon_d = cnt_q != MIN_LAST;
        end else if (!auto_en[i] || busy[i]) cnt_d = '0;
        else if (cnt_q == IDLE_LAST) begin
          state_d = GATED;
          cnt_d = '0;
        end else cnt_d = cnt_inc;
        GATED: if (!sw_en[i]) state_d = OFF;
        else if (busy[i] || !auto_en[i]) begin
          state_d = RUN;
          cnt_d = '0;
          mon_d = 1'b1;
          wake_d = 1'b1;
        end
        default: state_d = RUN;
      endcase
    end
    // channel state and registered status; reset leaves the clock running
    always_ff @(posedge in_clk) begin
      if (rst) begin
        state_q <= RUN;
        cnt_q <= '0;
        mon_q <= 1'b1;
        act_q <= 1'b1;
        wake_q <= 1'b0;
      end else begin
        state_q <= state_d;
        cnt_q <= cnt_d;
        mon_q <= mon_d;
        act_q <= state_d == RUN;
        wake_q <= wake_d;
      end
    end
    assign en_n_d[i] = rst | act_q;
    assign clk_active[i] = act_q;
    assign wake_pulse[i] = wake_q;
  end
  // enable only moves while in_clk is low, so gated pulses are always full width
  always_ff @(negedge in_clk) en_n_q <= en_n_d;
  assign out_clk = {N_CH{in_clk}} & en_n_q;
endmodule

// File: doc/clk_gate_ctrl.md
Name: clk_gate_ctrl

Overview:
- N-channel, glitch-free clock gating controller. It is the parametrised successor of the single-channel clk_gating cell.
- Each channel gates in_clk onto its own out_clk bit.
- Gating is controlled by a software enable, plus an optional auto-gating mode: the clock shuts off after a programmable number of idle cycles and wakes on a busy request.
- Sits between the clock source and per-subsystem clock domains for dynamic power reduction.

Parameters:
- N_CH, 4, number of independent gated clock channels (1..32).
- IDLE_CYCLES, 16, consecutive idle (busy=0) cycles in auto mode before a channel is gated (>=1).
- MIN_ON, 4, minimum in_clk cycles a channel stays ungated after a wake or enable (>=1).

Ports:
- in_clk  input  1  source clock; the only clock in the block.
- rst  input  1  synchronous, active-high reset.
- sw_en  input  N_CH  per-channel software enable; 0 forces the channel gated.
- auto_en  input  N_CH  per-channel auto-gating mode enable.
- busy  input  N_CH  per-channel activity request; only meaningful when auto_en=1.
- out_clk  output  N_CH  gated clocks.
- clk_active  output  N_CH  registered status; 1 when the channel FSM is in RUN.
- wake_pulse  output  N_CH  one-cycle pulse on the GATED->RUN transition.

Behaviour:
- All inputs are sampled on posedge in_clk. They are synchronous to in_clk; the block does no CDC.
- Per-channel FSM, registered on posedge, with states OFF, RUN, GATED. Each channel has its own counter cnt, CNT_W = clog2(max(IDLE_CYCLES, MIN_ON)+1).
- Reset (rst=1 at posedge):
  - state=RUN, cnt=0, clk_active=all 1, wake_pulse=0.
  - Clocks run during reset so that downstream synchronous resets complete.
- OFF:
  - Leave when sw_en=1: go to RUN with cnt=0 (min-on window starts).
- RUN:
  - sw_en=0 has priority: go to OFF next posedge.
  - For the first MIN_ON cycles after entry, the channel cannot gate; cnt counts the min-on window and busy is ignored.
  - After that, if auto_en=1: busy=1 clears cnt; busy=0 increments cnt. When busy=0 and cnt==IDLE_CYCLES-1, go to GATED.
  - auto_en=0: stay in RUN indefinitely; cnt is held at 0 once the min-on window has expired.
- GATED:
  - sw_en=0: go to OFF.
  - sw_en=1 and (busy=1 or auto_en=0): go to RUN with cnt=0, wake_pulse=1 for that one cycle.
  - sw_en=0 and busy=1 in the same cycle: OFF wins and no wake_pulse is issued.
- Gating cell:
  - en_n[i] is registered on negedge in_clk from (next state==RUN); it is forced to 1 when rst is sampled high on that negedge.
  - out_clk[i] = in_clk & en_n[i].
  - en_n only changes while in_clk is low, so there are no glitches or runt pulses.
- Latency:
  - Event sampled at posedge k (wake, or sw_en rise from OFF): first out_clk high pulse at posedge k+1.
  - Gate-off decided at posedge k: the posedge-k pulse on out_clk is complete, and no pulse is issued at k+1.
- Counters saturate and never wrap.
- With MIN_ON > IDLE_CYCLES, a channel with busy=0 gates MIN_ON+IDLE_CYCLES cycles after entering RUN.
- rst asserted mid-operation: every channel returns to RUN. out_clk resumes at the first posedge after the negedge that sampled rst.
- Channels are fully independent; there are no cross-channel interactions.

Test Plan:
- Reset, then sw_en=4'hF, auto_en=0 for 50 cycles -> out_clk matches in_clk on all channels, clk_active=4'hF, wake_pulse=0 throughout.
- Channel 0: auto_en=1, busy=0 from reset release (IDLE_CYCLES=16, MIN_ON=4) -> ch0 is gated after exactly 20 posedges; clk_active[0]=0; channels 1..3 keep toggling.
- Channel 0 gated, busy[0]=1 at posedge k -> wake_pulse[0]=1 for cycle k only; out_clk[0] first rises at posedge k+1; the channel then stays on for at least 4 cycles even if busy drops at k+1.
- sw_en[2] 1->0 at t=100ns, back to 1 at t=200ns (10ns clock) -> no out_clk[2] edges in between; every pulse is full-width, checked by a glitch monitor measuring the high time of each pulse (=5ns).
- Channel 1 gated, then sw_en[1]=0 and busy[1]=1 in the same cycle -> state OFF, no wake_pulse, out_clk[1] stays low.
- rst asserted for 2 cycles while channels 0,1 are GATED -> all clk_active=1, out_clk toggling on all channels within 1 cycle, and the idle count restarts from 0 after rst is released.
